// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM/WB pipeline register with result select, load alignment/extension and register-file write.
// Ports: clk/rst (async, active-high); in_* = instruction from MEM over in_valid/in_ready;
//        mem_rdata/mem_rvalid = data-memory read return; rf_we/rf_waddr/rf_wdata = register-file write;
//        wb_retire = one pulse per completed instruction; mem_unexp = pulse for a read return outside WAIT;
//        retire_count = retired-instruction counter, present only when WB_RETIRE_CNT_EN is defined.
module wb_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_retire,
    output logic              mem_unexp,
    output logic [63:0]       retire_count
);
    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;
    state_t state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d, rf_waddr_q, rf_waddr_d;
    logic [2:0] f3_q, f3_d, off_q, off_d, off_eff;
    logic rw_q, rw_d, rf_we_q, rf_we_d, retire_q, retire_d, unexp_q, unexp_d, accept;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d, sel_data, sh, ld_data;
    assign in_ready  = state_q != WAIT;
    assign accept    = in_valid && in_ready;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign wb_retire = retire_q;
    assign mem_unexp = unexp_q;
    assign sel_data  = in_wb_sel == 2'd2 ? in_pc_plus4 : in_wb_sel == 2'd3 ? in_imm : in_alu_result;
    // Offset is aligned down to the access size; bit2 only addresses bytes in a 64-bit word.
    always_comb begin
        off_eff = off_q & (f3_q[1:0] == 2'd0 ? 3'b111 : f3_q[1:0] == 2'd1 ? 3'b110 :
                           f3_q[1:0] == 2'd2 ? 3'b100 : 3'b000) & (XLEN == 64 ? 3'b111 : 3'b011);
        sh = mem_rdata >> {off_eff, 3'b000};
        ld_data = '0;
        case (f3_q)
            3'b000: ld_data = XLEN'($signed(sh[7:0]));
            3'b100: ld_data = XLEN'(sh[7:0]);
            3'b001: ld_data = XLEN'($signed(sh[15:0]));
            3'b101: ld_data = XLEN'(sh[15:0]);
            3'b010: ld_data = XLEN'($signed(sh[31:0]));
            3'b110: ld_data = XLEN == 64 ? XLEN'(sh[31:0]) : '0;
            3'b011: ld_data = XLEN == 64 ? mem_rdata : '0;
            default: ld_data = '0;
        endcase
    end
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rw_d       = rw_q;
        rf_we_d    = 1'b0;
        retire_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        unexp_d    = mem_rvalid && state_q != WAIT;
        if (state_q == WAIT) begin
            if (mem_rvalid) begin
                state_d    = COMMIT;
                rf_we_d    = rw_q && rd_q != '0;
                retire_d   = 1'b1;
                rf_waddr_d = rd_q;
                rf_wdata_d = ld_data;
            end
        end else if (accept && in_wb_sel == 2'd1) begin
            state_d = WAIT;
            rd_d    = in_rd;
            f3_d    = in_funct3;
            off_d   = in_alu_result[2:0];
            rw_d    = in_reg_write;
        end else if (accept) begin
            state_d    = COMMIT;
            rf_we_d    = in_reg_write && in_rd != '0;
            retire_d   = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = sel_data;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rw_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            retire_q   <= 1'b0;
            unexp_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rw_q       <= rw_d;
            rf_we_q    <= rf_we_d;
            retire_q   <= retire_d;
            unexp_q    <= unexp_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (retire_q) cnt_q <= cnt_q + 64'd1;
    end
    assign retire_count = cnt_q;
`else
    assign retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: random and directed checks of 32- and 64-bit wb_stage_pipe instances against a behavioural model.
module tb_wb_stage_pipe;
`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_reg_write = 1'b0, mem_rvalid = 1'b0;
    logic [4:0] in_rd = '0;
    logic [1:0] in_wb_sel = '0;
    logic [2:0] in_funct3 = '0;
    logic [63:0] in_alu = '0, in_pc4 = '0, in_imm = '0, mem_rdata = '0;
    logic rdy32, we32, ret32, unx32, rdy64, we64, ret64, unx64;
    logic [4:0] wa32, wa64;
    logic [31:0] wd32;
    logic [63:0] wd64, cnt32, cnt64;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .REG_AW(5)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu[31:0]),
        .in_pc_plus4(in_pc4[31:0]), .in_imm(in_imm[31:0]), .mem_rdata(mem_rdata[31:0]),
        .mem_rvalid(mem_rvalid), .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
        .wb_retire(ret32), .mem_unexp(unx32), .retire_count(cnt32));
    wb_stage_pipe #(.XLEN(64), .REG_AW(5)) d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu),
        .in_pc_plus4(in_pc4), .in_imm(in_imm), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
        .wb_retire(ret64), .mem_unexp(unx64), .retire_count(cnt64));

    function automatic logic [63:0] ref_sel(logic [1:0] s, logic [63:0] a, logic [63:0] p, logic [63:0] i);
        return s == 2'd2 ? p : s == 2'd3 ? i : a;
    endfunction

    // Load result from the RISC-V rules: n-byte access at an aligned-down offset, then extension.
    function automatic logic [63:0] ref_load(int xlen, logic [2:0] f3, logic [2:0] off, logic [63:0] d);
        logic [63:0] m, v;
        int n, o;
        m = xlen == 32 ? 64'h0000_0000_FFFF_FFFF : '1;
        if (f3 == 3'd7 || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6))) return 64'd0;
        n = 1 << f3[1:0];
        o = int'(off) % (xlen / 8);
        o = o - (o % n);
        v = (d & m) >> (8 * o);
        if (n < 8) begin
            v = v & ((64'd1 << (8 * n)) - 64'd1);
            if (!f3[2] && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v & m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        int s;
        s = $urandom_range(2, 0);
        in_wb_sel = s == 0 ? 2'd0 : 2'(s + 1);
        in_rd = 5'($urandom_range(31, 0));
        in_reg_write = 1'($urandom_range(1, 0));
        in_alu = {$urandom, $urandom};
        in_pc4 = {$urandom, $urandom};
        in_imm = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rdy32, we32, ret32, unx32, wa32, wd32, cnt32} !== {4'b1000, 5'd0, 32'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset32: rdy=%0b we=%0b ret=%0b unx=%0b wa=%0d wd=%h cnt=%0d, expected 1 0 0 0 0 0 0",
                     rdy32, we32, ret32, unx32, wa32, wd32, cnt32);
        end
        checks++;
        if ({rdy64, we64, ret64, unx64, wa64, wd64, cnt64} !== {4'b1000, 5'd0, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset64: rdy=%0b we=%0b ret=%0b unx=%0b wa=%0d wd=%h cnt=%0d, expected 1 0 0 0 0 0 0",
                     rdy64, we64, ret64, unx64, wa64, wd64, cnt64);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        logic [63:0] e;
        logic ew;
        logic [4:0] erd;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                in_wb_sel = 2'd0; in_rd = 5'd5; in_reg_write = 1'b1; in_alu = 64'h1234;
            end else rand_op();
            e = ref_sel(in_wb_sel, in_alu, in_pc4, in_imm);
            ew = in_reg_write && in_rd != 0;
            erd = in_rd;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if ({we32, ret32, wa32, wd32} !== {ew, 1'b1, erd, e[31:0]}) begin
                errors++;
                $display("FAIL alu32[%0d]: we=%0b ret=%0b wa=%0d wd=%h, expected we=%0b ret=1 wa=%0d wd=%h",
                         i, we32, ret32, wa32, wd32, ew, erd, e[31:0]);
            end
            checks++;
            if ({we64, ret64, wa64, wd64} !== {ew, 1'b1, erd, e}) begin
                errors++;
                $display("FAIL alu64[%0d]: we=%0b ret=%0b wa=%0d wd=%h, expected we=%0b ret=1 wa=%0d wd=%h",
                         i, we64, ret64, wa64, wd64, ew, erd, e);
            end
            tick();
            checks++;
            if ({we32, ret32, we64, ret64, wa32, wd32, wa64, wd64} !== {4'b0000, erd, e[31:0], erd, e}) begin
                errors++;
                $display("FAIL alu_hold[%0d]: we=%0b/%0b ret=%0b/%0b wa=%0d/%0d, expected zeros and held wa=%0d",
                         i, we32, we64, ret32, ret64, wa32, wa64, erd);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0] f3s [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd3};
        logic [2:0] offs [5] = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd0};
        logic [63:0] ds [5] = '{64'h0080_0000, 64'h0080_0000, 64'hBEEF_0000,
                                64'h8000_0001_0000_0000, 64'h0123_4567_89AB_CDEF};
        logic [63:0] d, e32, e64;
        logic [2:0] f3, off;
        logic ew;
        logic [4:0] erd;
        int w;
        for (int i = 0; i < 35; i++) begin
            f3 = i < 5 ? f3s[i] : 3'($urandom_range(7, 0));
            off = i < 5 ? offs[i] : 3'($urandom_range(7, 0));
            d = i < 5 ? ds[i] : {$urandom, $urandom};
            w = i < 5 ? 2 : $urandom_range(3, 0);
            in_wb_sel = 2'd1; in_funct3 = f3; in_alu = {$urandom, $urandom}; in_alu[2:0] = off;
            in_rd = i < 5 ? 5'd9 : 5'($urandom_range(31, 0));
            in_reg_write = i < 5 ? 1'b1 : 1'($urandom_range(1, 0));
            ew = in_reg_write && in_rd != 0;
            erd = in_rd;
            e32 = ref_load(32, f3, off, d);
            e64 = ref_load(64, f3, off, d);
            in_valid = 1'b1;
            checks++;
            if ({rdy32, rdy64} !== 2'b11) begin
                errors++;
                $display("FAIL load_ready[%0d]: rdy=%0b/%0b, expected 1/1", i, rdy32, rdy64);
            end
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < w; k++) begin
                checks++;
                if ({rdy32, rdy64, we32, we64, ret32, ret64} !== 6'b0) begin
                    errors++;
                    $display("FAIL load_wait[%0d]: rdy=%0b/%0b we=%0b/%0b ret=%0b/%0b, expected all 0",
                             i, rdy32, rdy64, we32, we64, ret32, ret64);
                end
                tick();
            end
            mem_rdata = d;
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            checks++;
            if ({we32, ret32, unx32, wa32, wd32} !== {ew, 2'b10, erd, e32[31:0]}) begin
                errors++;
                $display("FAIL load32[%0d] f3=%0d off=%0d: we=%0b ret=%0b unx=%0b wa=%0d wd=%h, expected we=%0b ret=1 unx=0 wa=%0d wd=%h",
                         i, f3, off, we32, ret32, unx32, wa32, wd32, ew, erd, e32[31:0]);
            end
            checks++;
            if ({we64, ret64, unx64, wa64, wd64} !== {ew, 2'b10, erd, e64}) begin
                errors++;
                $display("FAIL load64[%0d] f3=%0d off=%0d: we=%0b ret=%0b unx=%0b wa=%0d wd=%h, expected we=%0b ret=1 unx=0 wa=%0d wd=%h",
                         i, f3, off, we64, ret64, unx64, wa64, wd64, ew, erd, e64);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e, e32, e64;
        logic ew;
        logic [4:0] erd;
        for (int i = 0; i < 19; i++) begin
            if (i == 0) begin
                in_wb_sel = 2'd2; in_pc4 = 64'h104; in_rd = 5'd1; in_reg_write = 1'b1;
            end else if (i == 1) begin
                in_wb_sel = 2'd3; in_imm = 64'hABCD_E000; in_rd = 5'd2; in_reg_write = 1'b1;
            end else if (i == 2) begin
                in_wb_sel = 2'd0; in_alu = 64'h55; in_rd = 5'd0; in_reg_write = 1'b1;
            end else rand_op();
            e = ref_sel(in_wb_sel, in_alu, in_pc4, in_imm);
            ew = in_reg_write && in_rd != 0;
            erd = in_rd;
            in_valid = 1'b1;
            tick();
            checks++;
            if ({rdy32, rdy64, we32, ret32, wa32, wd32, we64, ret64, wa64, wd64} !==
                {2'b11, ew, 1'b1, erd, e[31:0], ew, 1'b1, erd, e}) begin
                errors++;
                $display("FAIL b2b[%0d]: rdy=%0b/%0b we=%0b/%0b ret=%0b/%0b wa=%0d/%0d wd=%h/%h, expected rdy=1 we=%0b ret=1 wa=%0d wd=%h",
                         i, rdy32, rdy64, we32, we64, ret32, ret64, wa32, wa64, wd32, wd64, ew, erd, e);
            end
        end
        in_wb_sel = 2'd1; in_funct3 = 3'd2; in_alu = 64'h100; in_rd = 5'd8; in_reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({rdy32, rdy64, ret32, ret64} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_load_wait: rdy=%0b/%0b ret=%0b/%0b, expected 0/0 0/0", rdy32, rdy64, ret32, ret64);
        end
        mem_rdata = 64'h1111_2222_8000_0000;
        e32 = ref_load(32, 3'd2, 3'd0, mem_rdata);
        e64 = ref_load(64, 3'd2, 3'd0, mem_rdata);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if ({we32, wa32, wd32, we64, wa64, wd64} !== {1'b1, 5'd8, e32[31:0], 1'b1, 5'd8, e64}) begin
            errors++;
            $display("FAIL b2b_load: we=%0b/%0b wa=%0d/%0d wd=%h/%h, expected we=1 wa=8 wd=%h/%h",
                     we32, we64, wa32, wa64, wd32, wd64, e32[31:0], e64);
        end
        tick();
    endtask

    task automatic test_unexp();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if ({unx32, unx64, we32, we64, ret32, ret64} !== 6'b110000) begin
            errors++;
            $display("FAIL unexp_idle: unx=%0b/%0b we=%0b/%0b ret=%0b/%0b, expected unx=1 we=0 ret=0",
                     unx32, unx64, we32, we64, ret32, ret64);
        end
        tick();
        checks++;
        if ({unx32, unx64} !== 2'b00) begin
            errors++;
            $display("FAIL unexp_pulse: unx=%0b/%0b, expected 0/0", unx32, unx64);
        end
        in_wb_sel = 2'd1; in_funct3 = 3'd4; in_alu = 64'h1; in_rd = 5'd3; in_reg_write = 1'b1;
        in_valid = 1'b1;
        mem_rdata = 64'hAB00;
        mem_rvalid = 1'b1;
        tick();
        in_valid = 1'b0;
        mem_rvalid = 1'b0;
        checks++;
        if ({unx32, unx64, rdy32, rdy64, ret32, ret64} !== 6'b110000) begin
            errors++;
            $display("FAIL unexp_accept: unx=%0b/%0b rdy=%0b/%0b ret=%0b/%0b, expected unx=1 rdy=0 ret=0",
                     unx32, unx64, rdy32, rdy64, ret32, ret64);
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if ({unx32, unx64, we32, we64, wd32, wd64} !== {4'b0011, 32'hAB, 64'hAB}) begin
            errors++;
            $display("FAIL unexp_then_load: unx=%0b/%0b we=%0b/%0b wd=%h/%h, expected unx=0 we=1 wd=ab",
                     unx32, unx64, we32, we64, wd32, wd64);
        end
        tick();
        in_funct3 = 3'd0; in_rd = 5'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if ({rdy32, rdy64, we32, we64, ret32, ret64, wa32, wa64, wd32, wd64} !== {6'b110000, 10'd0, 96'd0}) begin
            errors++;
            $display("FAIL reset_wait: rdy=%0b/%0b we=%0b/%0b ret=%0b/%0b wa=%0d/%0d wd=%h/%h, expected rdy=1 rest 0",
                     rdy32, rdy64, we32, we64, ret32, ret64, wa32, wa64, wd32, wd64);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({rdy32, rdy64, we32, we64, ret32, ret64} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_wait_after: rdy=%0b/%0b we=%0b/%0b ret=%0b/%0b, expected rdy=1 we=0 ret=0",
                     rdy32, rdy64, we32, we64, ret32, ret64);
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if ({unx32, unx64, we32, we64, ret32, ret64} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_stray: unx=%0b/%0b we=%0b/%0b ret=%0b/%0b, expected unx=1 we=0 ret=0",
                     unx32, unx64, we32, we64, ret32, ret64);
        end
        tick();
    endtask

    task automatic test_count();
        logic [63:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
        e = CNT_EN ? 64'd10 : 64'd0;
        checks++;
        if ({cnt32, cnt64} !== {e, e}) begin
            errors++;
            $display("FAIL count: cnt=%0d/%0d, expected %0d", cnt32, cnt64, e);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({cnt32, cnt64} !== 128'd0) begin
            errors++;
            $display("FAIL count_reset: cnt=%0d/%0d, expected 0", cnt32, cnt64);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_unexp();
        test_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
